led_game_sequencer: RTL and testbench

//  Run controller for the two-walker LED bounce game. It replaces derived divider clocks with

---
 rtl/led_game_sequencer.sv | 131 +++++++++++++
 tb/tb_led_game_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_game_sequencer.sv
// Run controller for the two-walker LED bounce game: step enables for both walkers,
// Mr1 direction, bounce counting and the IDLE/RUN/PAUSE/OVER sequence.
module led_game_sequencer #(
  parameter int unsigned TICK_DIV   = 8388608,
  parameter int unsigned MR3_RATIO  = 4,
  parameter int unsigned MAX_BOUNCE = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       speed,
  input  logic       collide,
  output logic       load_init,
  output logic       mr1_step,
  output logic       mr3_step,
  output logic       dir,
  output logic [1:0] state,
  output logic [7:0] bounce_cnt,
  output logic       game_over
);

  localparam int unsigned CW = $clog2(2 * TICK_DIV);
  localparam int unsigned SW = (MR3_RATIO > 1) ? $clog2(MR3_RATIO) : 1;
  localparam logic [CW-1:0] LastFast   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LastSlow   = CW'(2 * TICK_DIV - 1);
  localparam logic [SW-1:0] SubLast    = SW'(MR3_RATIO - 1);
  localparam logic [7:0]    BounceEnd  = 8'(MAX_BOUNCE);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StOver  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sub_q, sub_d;
  logic          spd_q, spd_d;
  logic          dir_q, dir_d;
  logic [7:0]    bounce_q, bounce_d;
  logic          load_q, load_d;
  logic          mr1_q, mr1_d;
  logic          mr3_q, mr3_d;
  logic          over_q, over_d;
  logic [CW-1:0] cnt_last;

  assign cnt_last = spd_q ? LastSlow : LastFast;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    spd_d    = spd_q;
    dir_d    = dir_q;
    bounce_d = bounce_q;
    load_d   = 1'b0;
    mr1_d    = 1'b0;
    mr3_d    = 1'b0;
    if (start) begin
      state_d  = StRun;
      cnt_d    = '0;
      sub_d    = '0;
      bounce_d = '0;
      dir_d    = 1'b1;
      load_d   = 1'b1;
      spd_d    = speed;
    end else begin
      case (state_q)
        StRun: begin
          if (pause) begin
            state_d = StPause;
          end else if (cnt_q == cnt_last) begin
            cnt_d = '0;
            mr1_d = 1'b1;
            spd_d = speed;
            mr3_d = (sub_q == SubLast);
            sub_d = (sub_q == SubLast) ? '0 : sub_q + SW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StPause: if (pause) state_d = StRun;
        default: ;
      endcase
      // collide reflects the pre-move positions presented while mr1_step is high
      if (mr1_q && collide) begin
        dir_d = ~dir_q;
        if (bounce_q != 8'hFF) bounce_d = bounce_q + 8'd1;
        if (bounce_d == BounceEnd) state_d = StOver;
      end
    end
    over_d = (state_d == StOver);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sub_q    <= '0;
      spd_q    <= 1'b0;
      dir_q    <= 1'b1;
      bounce_q <= '0;
      load_q   <= 1'b0;
      mr1_q    <= 1'b0;
      mr3_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      spd_q    <= spd_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
      load_q   <= load_d;
      mr1_q    <= mr1_d;
      mr3_q    <= mr3_d;
      over_q   <= over_d;
    end
  end

  assign load_init  = load_q;
  assign mr1_step   = mr1_q;
  assign mr3_step   = mr3_q;
  assign dir        = dir_q;
  assign state      = state_q;
  assign bounce_cnt = bounce_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_led_game_sequencer.sv
// Bench for led_game_sequencer: directed game scenarios plus random traffic, every cycle
// compared against an interval/step-count model of the game rules.
module tb_led_game_sequencer;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned MR3_RATIO  = 4;
  localparam int unsigned MAX_BOUNCE = 3;

  logic       clk, rst, start, pause, speed, collide;
  logic       load_init, mr1_step, mr3_step, dir, game_over;
  logic [1:0] state;
  logic [7:0] bounce_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  led_game_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .MR3_RATIO (MR3_RATIO),
    .MAX_BOUNCE(MAX_BOUNCE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .speed     (speed),
    .collide   (collide),
    .load_init (load_init),
    .mr1_step  (mr1_step),
    .mr3_step  (mr3_step),
    .dir       (dir),
    .state     (state),
    .bounce_cnt(bounce_cnt),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 idle, 1 run, 2 pause, 3 over; elapsed counts run edges since the last step
  int m_st, m_elapsed, m_steps, m_bounce;
  bit m_spd, m_dir, m_load, m_mr1, m_mr3;

  function automatic int period(input bit s);
    return s ? 2 * TICK_DIV : TICK_DIV;
  endfunction

  task automatic model_reset();
    m_st = 0; m_elapsed = 0; m_steps = 0; m_bounce = 0;
    m_spd = 0; m_dir = 1; m_load = 0; m_mr1 = 0; m_mr3 = 0;
  endtask

  task automatic model_edge();
    bit was_step;
    was_step = m_mr1;
    m_load = 0; m_mr1 = 0; m_mr3 = 0;
    if (start) begin
      m_st = 1; m_elapsed = 0; m_steps = 0; m_bounce = 0;
      m_dir = 1; m_load = 1; m_spd = speed;
      return;
    end
    if (m_st == 1 && pause) m_st = 2;
    else if (m_st == 2 && pause) m_st = 1;
    else if (m_st == 1) begin
      m_elapsed++;
      if (m_elapsed == period(m_spd)) begin
        m_elapsed = 0;
        m_mr1 = 1;
        m_steps++;
        m_mr3 = (m_steps % MR3_RATIO == 0);
        m_spd = speed;
      end
    end
    if (was_step && collide) begin
      m_dir = !m_dir;
      if (m_bounce < 255) m_bounce++;
      if (m_bounce == MAX_BOUNCE) m_st = 3;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/state"},  {6'd0, state},    8'(m_st));
    check({tag, "/dir"},    {7'd0, dir},      {7'd0, m_dir});
    check({tag, "/bounce"}, bounce_cnt,       8'(m_bounce));
    check({tag, "/load"},   {7'd0, load_init}, {7'd0, m_load});
    check({tag, "/mr1"},    {7'd0, mr1_step}, {7'd0, m_mr1});
    check({tag, "/mr3"},    {7'd0, mr3_step}, {7'd0, m_mr3});
    check({tag, "/over"},   {7'd0, game_over}, {7'd0, bit'(m_st == 3)});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1 check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    cycle(tag);
    rst = 1'b0;
  endtask

  // Cycles until mr1_step is seen, bounded by limit
  task automatic wait_step(input string tag, input int limit, output int n);
    n = 0;
    do begin
      cycle(tag);
      n++;
    end while (!mr1_step && n < limit);
  endtask

  task automatic pulse(input string tag, input bit s, input bit p);
    start = s; pause = p;
    cycle(tag);
    start = 0; pause = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 0; pause = 0; speed = 0; collide = 0;
    model_reset();
    #1 check_all("reset_init");
    repeat (3) cycle("reset_hold");
    rst = 1'b0;

    // Idle: random pause/speed/collide must not wake the sequencer
    for (int i = 0; i < 100; i++) begin
      pause = 1'($urandom_range(0, 1)); speed = 1'($urandom_range(0, 1));
      collide = 1'($urandom_range(0, 1));
      cycle("idle");
    end
    pause = 0; speed = 0; collide = 0;

    pulse("start", 1, 0);
    check("start_load", {7'd0, load_init}, 8'd1);
    wait_step("first_step", 20, n);
    check("first_step_gap", 8'(n), 8'(TICK_DIV));
    wait_step("second_step", 20, n);
    check("second_step_gap", 8'(n), 8'(TICK_DIV));
    speed = 1;
    wait_step("third_step", 20, n);
    check("third_step_gap", 8'(n), 8'(TICK_DIV));
    wait_step("fourth_step", 20, n);
    check("fourth_step_gap", 8'(n), 8'(2 * TICK_DIV));
    check("fourth_mr3", {7'd0, mr3_step}, 8'd1);

    collide = 1;
    n = 0;
    while (!game_over && n < 200) begin
      cycle("bounce");
      n++;
    end
    check("over_state", {6'd0, state}, 8'd3);
    check("over_bounce", bounce_cnt, 8'(MAX_BOUNCE));
    for (int i = 0; i < 30; i++) begin
      collide = 1'($urandom_range(0, 1)); pause = 1'($urandom_range(0, 1));
      cycle("over_hold");
    end
    collide = 0; pause = 0; speed = 0;

    // Pause two cycles after a step, hold, resume
    pulse("restart", 1, 0);
    wait_step("pre_pause", 20, n);
    cycle("pre_pause");
    cycle("pre_pause");
    pulse("pause_on", 0, 1);
    check("paused_state", {6'd0, state}, 8'd2);
    repeat (50) cycle("paused");
    pulse("pause_off", 0, 1);
    wait_step("resume_step", 20, n);
    check("resume_gap", 8'(n), 8'd2);

    repeat (3) cycle("run_mid");
    async_reset("rst_mid_run");
    pulse("start2", 1, 0);
    repeat (5) cycle("run2");
    pulse("pause2", 0, 1);
    pulse("start_pause", 1, 1);
    check("sp_load", {7'd0, load_init}, 8'd1);
    check("sp_state", {6'd0, state}, 8'd1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) async_reset("rand_rst");
      start   = ($urandom_range(0, 59) == 0);
      pause   = ($urandom_range(0, 24) == 0);
      collide = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) speed = 1'($urandom_range(0, 1));
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
